// File: rtl/air_hockey_pkg.sv
// Shared air-hockey constants: FSM encoding, table geometry and puck/paddle sizes.
// Single source for the puck controller and the match sequencer.
package air_hockey_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_GOAL  = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam int unsigned LEFT_WALL_X    = 44;
  localparam int unsigned RIGHT_WALL_X   = 979;
  localparam int unsigned GOAL_Y_MIN     = 312;
  localparam int unsigned GOAL_Y_MAX     = 412;
  localparam int unsigned CENTER_X       = 487;
  localparam int unsigned CENTER_Y       = 362;
  localparam int unsigned RADIUS_BALL    = 10;
  localparam int unsigned PLAYERS_RADIUS = 20;

  function automatic logic in_range13(input logic [12:0] v, input logic [12:0] lo,
                                      input logic [12:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/step_burst_gen.sv
// Turns a frame tick into STEPS consecutive one-cycle ball_step pulses, starting the cycle after the tick.
// Ticks during an active burst are dropped; abort or !enable kill the burst on the next edge.
module step_burst_gen #(
  parameter int unsigned STEPS = 4
) (
  input  logic clk_in,
  input  logic rst,
  input  logic enable,
  input  logic abort,
  input  logic frame_tick,
  output logic ball_step
);

  // Pulses still owed after the one currently on ball_step.
  logic [3:0] remain;

  always_ff @(posedge clk_in) begin
    if (rst || abort || !enable) begin
      remain    <= 4'd0;
      ball_step <= 1'b0;
    end else if (frame_tick && !ball_step && (remain == 4'd0)) begin
      remain    <= 4'(STEPS - 1);
      ball_step <= 1'b1;
    end else if (remain != 4'd0) begin
      remain    <= remain - 4'd1;
      ball_step <= 1'b1;
    end else begin
      ball_step <= 1'b0;
    end
  end

endmodule

// File: rtl/game_flow_ctl.sv
// Match sequencer: serve hold, per-frame step bursts, goal detection and scoring up to WIN_SCORE.
// All outputs registered; a cause at cycle t takes effect at t+1. No backpressure.
module game_flow_ctl #(
  parameter int unsigned LEFT_WALL_X     = air_hockey_pkg::LEFT_WALL_X,
  parameter int unsigned RIGHT_WALL_X    = air_hockey_pkg::RIGHT_WALL_X,
  parameter int unsigned GOAL_Y_MIN      = air_hockey_pkg::GOAL_Y_MIN,
  parameter int unsigned GOAL_Y_MAX      = air_hockey_pkg::GOAL_Y_MAX,
  parameter int unsigned RADIUS_BALL     = air_hockey_pkg::RADIUS_BALL,
  parameter int unsigned SERVE_FRAMES    = 60,
  parameter int unsigned STEPS_PER_FRAME = 4,
  parameter int unsigned WIN_SCORE       = 7
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic [11:0] xpos_ball,
  input  logic [11:0] ypos_ball,
  output logic        ball_step,
  output logic        ball_reload,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic        goal_pulse,
  output logic        game_over,
  output logic        winner,
  output logic [2:0]  state
);
  import air_hockey_pkg::*;

  // Limits are formed in 13 bits on the constant side so xpos_ball is never subtracted from.
  localparam logic [12:0] LEFT_LIM  = 13'(LEFT_WALL_X + RADIUS_BALL);
  localparam logic [12:0] RIGHT_LIM = 13'(RIGHT_WALL_X - RADIUS_BALL);
  localparam logic [12:0] Y_MIN     = 13'(GOAL_Y_MIN);
  localparam logic [12:0] Y_MAX     = 13'(GOAL_Y_MAX);
  localparam logic [3:0]  WIN       = 4'(WIN_SCORE);
  localparam logic [15:0] SERVE_END = 16'(SERVE_FRAMES - 1);

  logic        start_prev;
  logic        start_edge;
  logic [15:0] serve_cnt;
  logic        scorer_p2;
  logic [12:0] x13;
  logic [12:0] y13;
  logic        y_ok;
  logic        goal_l;
  logic        goal_r;
  logic        goal_det;
  logic        in_play;

  assign start_edge = start_btn & ~start_prev;
  assign x13        = {1'b0, xpos_ball};
  assign y13        = {1'b0, ypos_ball};
  assign y_ok       = in_range13(y13, Y_MIN, Y_MAX);
  assign in_play    = (state == ST_PLAY);
  assign goal_l     = in_play && y_ok && (x13 <= LEFT_LIM);
  assign goal_r     = in_play && y_ok && (x13 >= RIGHT_LIM) && !goal_l;
  assign goal_det   = goal_l || goal_r;

  step_burst_gen #(
    .STEPS (STEPS_PER_FRAME)
  ) u_burst (
    .clk_in     (clk_in),
    .rst        (rst),
    .enable     (in_play),
    .abort      (goal_det),
    .frame_tick (frame_tick),
    .ball_step  (ball_step)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= ST_IDLE;
      score_p1    <= 4'd0;
      score_p2    <= 4'd0;
      ball_reload <= 1'b1;
      goal_pulse  <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      serve_cnt   <= 16'd0;
      start_prev  <= 1'b0;
      scorer_p2   <= 1'b0;
    end else begin
      start_prev <= start_btn;
      goal_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          ball_reload <= 1'b1;
          if (start_edge) begin
            score_p1  <= 4'd0;
            score_p2  <= 4'd0;
            serve_cnt <= 16'd0;
            state     <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (serve_cnt == SERVE_END) begin
              serve_cnt   <= 16'd0;
              ball_reload <= 1'b0;
              state       <= ST_PLAY;
            end else begin
              serve_cnt <= serve_cnt + 16'd1;
            end
          end
        end
        ST_PLAY: begin
          if (goal_det) begin
            state       <= ST_GOAL;
            goal_pulse  <= 1'b1;
            ball_reload <= 1'b1;
            scorer_p2   <= goal_l;
            if (goal_l) begin
              if (score_p2 < WIN) score_p2 <= score_p2 + 4'd1;
            end else begin
              if (score_p1 < WIN) score_p1 <= score_p1 + 4'd1;
            end
          end
        end
        ST_GOAL: begin
          // Scores were already updated on entry, so this compares the new value.
          if ((scorer_p2 ? score_p2 : score_p1) == WIN) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
            winner    <= scorer_p2;
          end else begin
            state <= ST_SERVE;
          end
        end
        ST_OVER: begin
          ball_reload <= 1'b1;
          if (start_edge) begin
            score_p1  <= 4'd0;
            score_p2  <= 4'd0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            serve_cnt <= 16'd0;
            state     <= ST_SERVE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          ball_reload <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_ctl.sv
// Scoreboard bench for game_flow_ctl: stimulus queues expected step/goal events, a negedge monitor checks them.
module tb_game_flow_ctl;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        start_btn;
  logic [11:0] xpos_ball;
  logic [11:0] ypos_ball;
  logic        ball_step;
  logic        ball_reload;
  logic [3:0]  score_p1;
  logic [3:0]  score_p2;
  logic        goal_pulse;
  logic        game_over;
  logic        winner;
  logic [2:0]  state;

  typedef struct {
    bit is_goal;
    int cyc;
    int p1;
    int p2;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  game_flow_ctl dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start_btn   (start_btn),
    .xpos_ball   (xpos_ball),
    .ypos_ball   (ypos_ball),
    .ball_step   (ball_step),
    .ball_reload (ball_reload),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .goal_pulse  (goal_pulse),
    .game_over   (game_over),
    .winner      (winner),
    .state       (state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every step or goal pulse must match the head of the expected-event queue.
  always @(negedge clk_in) begin
    if (ball_step === 1'b1 || goal_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: step=%0b goal=%0b at cycle %0d, expected none",
                 ball_step, goal_pulse, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_is_goal", goal_pulse, mon_e.is_goal);
        chk("event_cycle", cyc, mon_e.cyc);
        if (mon_e.is_goal) begin
          chk("goal_score_p1", score_p1, mon_e.p1);
          chk("goal_score_p2", score_p2, mon_e.p2);
        end
      end
    end
  end

  task automatic step1();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) step1();
  endtask

  task automatic center();
    xpos_ball = 12'd487;
    ypos_ball = 12'd362;
  endtask

  task automatic do_tick(input int nexp);
    for (int i = 0; i < nexp; i++) exp_q.push_back('{1'b0, cyc + 1 + i, 0, 0});
    frame_tick = 1'b1;
    step1();
    frame_tick = 1'b0;
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    step1();
    start_btn = 1'b0;
    chk("start_state", state, 1);
    chk("start_reload", ball_reload, 1);
    chk("start_p1", score_p1, 0);
    chk("start_p2", score_p2, 0);
    chk("start_game_over", game_over, 0);
  endtask

  task automatic serve();
    for (int i = 0; i < 60; i++) begin
      if (i == 59) chk("serve_hold_state", state, 1);
      do_tick(0);
      if (i < 59) step1();
    end
    chk("play_state", state, 2);
    chk("play_reload", ball_reload, 0);
    step1();
  endtask

  task automatic goal(input int x, input int y, input int p1, input int p2, input bit over);
    xpos_ball = 12'(x);
    ypos_ball = 12'(y);
    exp_q.push_back('{1'b1, cyc + 1, p1, p2});
    step1();
    chk("goal_state", state, 3);
    chk("goal_reload", ball_reload, 1);
    center();
    step1();
    chk("post_goal_state", state, over ? 4 : 1);
    chk("post_goal_reload", ball_reload, 1);
    chk("post_goal_game_over", game_over, over);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_reload"}, ball_reload, 1);
    chk({tag, "_p1"}, score_p1, 0);
    chk({tag, "_p2"}, score_p2, 0);
    chk({tag, "_step"}, ball_step, 0);
    chk({tag, "_goal_pulse"}, goal_pulse, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_winner"}, winner, 0);
  endtask

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    start_btn  = 1'b0;
    center();
    cycles(3);
    chk_reset_vals("reset");
    rst = 1'b0;
    cycles(2);
    chk("idle_state", state, 0);
    chk("idle_reload", ball_reload, 1);

    press_start();
    serve();

    // Bursts: four consecutive steps; a tick inside a burst adds nothing.
    do_tick(4);
    chk("burst_first_step", ball_step, 1);
    cycles(6);
    do_tick(4);
    step1();
    do_tick(0);
    cycles(6);

    goal(54, 362, 0, 1, 1'b0);
    serve();

    // Puck at the goal line but below the y window: no goal.
    xpos_ball = 12'd54;
    ypos_ball = 12'd300;
    cycles(5);
    chk("no_goal_state", state, 2);
    chk("no_goal_p2", score_p2, 1);
    center();
    step1();

    // Right goal one cycle into a burst: only the first step survives.
    do_tick(1);
    goal(969, 412, 1, 1, 1'b0);
    cycles(6);
    serve();

    for (int g = 2; g <= 7; g++) begin
      goal(969, 412, g, 1, g == 7);
      if (g < 7) serve();
    end
    chk("over_winner", winner, 0);
    chk("over_p1", score_p1, 7);
    chk("over_p2", score_p2, 1);

    xpos_ball = 12'd54;
    ypos_ball = 12'd362;
    do_tick(0);
    cycles(4);
    chk("frozen_state", state, 4);
    chk("frozen_p1", score_p1, 7);
    chk("frozen_p2", score_p2, 1);
    chk("frozen_game_over", game_over, 1);
    center();

    press_start();
    serve();

    goal(969, 362, 1, 0, 1'b0);
    serve();
    goal(975, 312, 2, 0, 1'b0);
    serve();
    goal(969, 400, 3, 0, 1'b0);
    serve();
    goal(10, 320, 3, 1, 1'b0);
    serve();
    goal(44, 412, 3, 2, 1'b0);
    serve();

    // Reset in the middle of a burst at 3:2.
    do_tick(1);
    rst = 1'b1;
    step1();
    chk_reset_vals("midrst");
    rst = 1'b0;
    cycles(4);
    chk("midrst_after_state", state, 0);
    chk("midrst_after_step", ball_step, 0);

    cycles(2);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
